// File: rtl/pwm_pkg.sv
// pwm_pkg: shared state encoding and constants for the pwm fade sequencer
package pwm_pkg;
    typedef enum logic [1:0] {IDLE, LOAD, WAIT, STEP} state_t;
    localparam int CNT_W_DEF = 20;
    localparam int MIN_VAL = 1;
endpackage

// File: rtl/pwm_step_calc.sv
// pwm_step_calc: saturating one-step move of the high-pulse width toward target
module pwm_step_calc #(
    parameter int CNT_W = 20
) (
    input  logic [CNT_W-1:0] cur,
    input  logic [CNT_W-1:0] target,
    input  logic [CNT_W-1:0] step,
    output logic [CNT_W-1:0] hpw_next
);
    logic [CNT_W:0]   sum;
    logic [CNT_W-1:0] diff;
    assign sum  = {1'b0, cur} + {1'b0, step};
    assign diff = cur - target;
    always_comb hpw_next = (cur < target) ? ((sum > {1'b0, target}) ? target : sum[CNT_W-1:0])
                                          : ((diff <= step) ? target : cur - step);
endmodule

// File: rtl/pwm_fade_ctrl.sv
// pwm_fade_ctrl: ramps a pwm core's high-pulse width to a target, updating only on period boundaries
module pwm_fade_ctrl
    import pwm_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int DIV_W = 8
) (
    input  logic             i_sysclk,
    input  logic             i_arstn,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic [CNT_W-1:0] i_period,
    input  logic [CNT_W-1:0] i_target,
    input  logic [CNT_W-1:0] i_step,
    input  logic [DIV_W-1:0] i_div,
    input  logic             i_pa,
    output logic             o_pv,
    output logic [CNT_W-1:0] o_period,
    output logic [CNT_W-1:0] o_hpw,
    output logic             o_busy,
    output logic             o_done
);
    state_t           state;
    logic [CNT_W-1:0] period_r, target_r, step_r, hpw_next;
    logic [DIV_W-1:0] div_r, cnt;

    pwm_step_calc #(.CNT_W(CNT_W)) u_calc (
        .cur     (o_hpw),
        .target  (target_r),
        .step    (step_r),
        .hpw_next(hpw_next)
    );

    always_ff @(posedge i_sysclk or negedge i_arstn) begin
        if (!i_arstn) begin
            state    <= IDLE;
            period_r <= '0;
            target_r <= '0;
            step_r   <= '0;
            div_r    <= '0;
            cnt      <= '0;
            o_pv     <= 1'b0;
            o_period <= '0;
            o_hpw    <= '0;
            o_busy   <= 1'b0;
            o_done   <= 1'b0;
        end else begin
            o_pv   <= 1'b0;
            o_done <= 1'b0;
            if (i_abort && state != IDLE) begin
                state  <= IDLE;
                o_busy <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (i_start && !i_abort) begin
                        period_r <= i_period;
                        target_r <= (i_target > i_period) ? i_period : i_target;
                        step_r   <= (i_step == '0) ? CNT_W'(MIN_VAL) : i_step;
                        div_r    <= (i_div == '0) ? DIV_W'(MIN_VAL) : i_div;
                        o_busy   <= 1'b1;
                        state    <= LOAD;
                    end
                    LOAD: if (i_pa) begin
                        o_pv     <= 1'b1;
                        o_period <= period_r;
                        cnt      <= div_r;
                        if (o_hpw == target_r) begin
                            o_done <= 1'b1;
                            o_busy <= 1'b0;
                            state  <= IDLE;
                        end else begin
                            state <= WAIT;
                        end
                    end
                    WAIT: if (i_pa) begin
                        if (cnt == DIV_W'(1)) state <= STEP;
                        else cnt <= cnt - DIV_W'(1);
                    end
                    STEP: begin
                        o_hpw <= hpw_next;
                        o_pv  <= 1'b1;
                        if (hpw_next == target_r) begin
                            o_done <= 1'b1;
                            o_busy <= 1'b0;
                            state  <= IDLE;
                        end else begin
                            cnt   <= div_r;
                            state <= WAIT;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: doc/pwm_fade_ctrl.md
Name: pwm_fade_ctrl

Overview:
Sequencer that programs a pwm core's period and high-pulse-width registers. It ramps the duty cycle from the current high-pulse width to a target in fixed steps, for soft-start or fade.
Updates are issued only on PWM period boundaries, as reported by the core's period-boundary pulse, so every period the core emits is glitch-free.
The block sits between the CPU/register interface and a single pwm instance.

Parameters:
CNT_W, 20, width of period / high-pulse-width / step values (matches pwm core)
DIV_W, 8, width of periods-per-step divider

Ports:
i_sysclk  in  1  system clock
i_arstn  in  1  asynchronous active-low reset
i_start  in  1  1-cycle pulse: latch config, begin ramp (ignored while o_busy)
i_abort  in  1  1-cycle pulse: stop ramp, hold current outputs
i_period  in  CNT_W  PWM period to program
i_target  in  CNT_W  target high-pulse width
i_step  in  CNT_W  hpw change per step (0 treated as 1)
i_div  in  DIV_W  PWM periods per step (0 treated as 1)
i_pa  in  1  period-boundary pulse from pwm core (1 cycle per period)
o_pv  out  1  1-cycle parameter-valid strobe to pwm core
o_period  out  CNT_W  period value to pwm core
o_hpw  out  CNT_W  high-pulse width to pwm core
o_busy  out  1  ramp in progress
o_done  out  1  1-cycle pulse: target reached

Behaviour:
- Clock and reset: one clock i_sysclk; reset is asynchronous and active-low (i_arstn).
- Reset values: state IDLE; o_pv=0, o_period=0, o_hpw=0, o_busy=0, o_done=0; internal regs 0.
- All outputs are registered.
- o_period and o_hpw change only in the cycle o_pv=1; otherwise they hold.
- States: IDLE, LOAD, WAIT, STEP.
- IDLE:
  - o_busy=0.
  - On i_start (and no i_abort): latch period=i_period, target=min(i_target, i_period), step=max(i_step,1), div=max(i_div,1).
  - Then go to LOAD; o_busy=1 from the next cycle.
- LOAD:
  - On i_pa: next cycle o_pv=1 and o_period=latched period; o_hpw unchanged; div counter is loaded with div.
  - If o_hpw==target, o_done=1 in the same cycle as o_pv and the block returns to IDLE.
  - Otherwise go to WAIT.
- WAIT: each i_pa decrements the div counter. An i_pa arriving when the counter is 1 moves the block to STEP.
- STEP (1 cycle):
  - Increasing: next = min(o_hpw+step, target), computed in CNT_W+1 bits, with no wrap.
  - Decreasing: next = (o_hpw-target <= step) ? target : o_hpw-step, with no underflow.
  - o_hpw<=next and o_pv=1 for 1 cycle.
  - If next==target: o_done=1 that same cycle, then IDLE.
  - Otherwise reload the div counter and go to WAIT.
- Latency:
  - o_pv asserts exactly 1 cycle after a qualifying i_pa (LOAD).
  - In the STEP path, o_pv asserts 2 cycles after the qualifying i_pa (i_pa cycle, then the STEP cycle).
  - STEP completes before the next i_pa; the pwm core's minimum period is 2 cycles, so an i_pa arriving in the STEP cycle cannot occur.
- i_abort in any non-IDLE state: next state IDLE; o_busy=0 next cycle; no o_pv and no o_done; o_hpw/o_period keep their last programmed values.
- i_abort and i_start in the same cycle: abort wins, the block stays IDLE, and nothing is latched.
- i_start while busy: ignored; the latched config is unchanged.
- Live input changes: i_period/i_target/i_step/i_div changes after the start cycle have no effect.
- Target above period: target is clamped to period, so hpw never exceeds period.
- Reset mid-ramp: all outputs return immediately (asynchronously) to reset values.

Decomposition:
- Shared package pwm_pkg:
  - state enum (IDLE, LOAD, WAIT, STEP)
  - CNT_W default constant
  - helper constant for max(x,1) clamping of zero step/div
- One sub-module, pwm_step_calc:
  - combinational saturating step toward target
  - inputs: cur, target, step
  - output: next hpw
  - width CNT_W, internal CNT_W+1 sum

Test Plan:
1. Reset then idle: i_arstn low for 2 cycles, then high; no i_start -> all outputs 0, o_pv never asserts.
2. Ramp up: i_pa every 4 cycles; start with period=10, target=8, step=3, div=1 -> o_pv strobes with (o_period,o_hpw) = (10,0), then (10,3), (10,6), (10,8); o_done coincides with the last strobe; o_busy then drops.
3. Ramp down with divider: continuing from o_hpw=8, start with target=1, step=2, div=3 -> hpw sequence 6, 4, 2, 1. Successive updates are 3 i_pa pulses apart; the final step saturates at 1, not -1/wrap.
4. Clamp and zero handling: start with period=4, target=9, step=0, div=0 -> target clamps to 4, step=1, div=1. hpw increments by 1 per period up to 4, then o_done.
5. Abort mid-ramp: start period=10, target=8, step=1; assert i_abort after the 3rd strobe (hpw=2) -> no further o_pv, no o_done, o_hpw stays 2, o_busy=0. Simultaneous i_start+i_abort in IDLE -> stays IDLE.
6. Busy start ignored and async reset: pulse i_start with target=0 during an active ramp -> ramp continues to its original target. Drop i_arstn mid-WAIT -> outputs are 0 in that same cycle.
